// File: rtl/cart_bus_arbiter.sv
// Cartridge memory port arbiter: shares the port between 6502 fetches and the SPI
// loader, sequences CPU reset around loads and implements F8/F6/F4 bank hotspots.
module cart_bus_arbiter #(
  parameter int unsigned ADDR_BITS      = 15,
  parameter int unsigned RELEASE_CYCLES = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpu_en,
  input  logic [12:0]          cpu_addr,
  input  logic                 spi_wr,
  input  logic [31:0]          spi_addr,
  input  logic [7:0]           spi_data,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_we,
  output logic [7:0]           mem_wdata,
  output logic                 cpu_reset,
  output logic                 spi_busy,
  output logic                 overflow,
  output logic [2:0]           bank,
  output logic [1:0]           scheme
);

  localparam int unsigned CntW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(RELEASE_CYCLES - 1);

  typedef enum logic [1:0] {StLoad, StRelease, StRun} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [7:0]            ctrl_q, ctrl_d;
  logic                  buf_full_q, buf_full_d;
  logic [ADDR_BITS-1:0]  buf_addr_q, buf_addr_d;
  logic [7:0]            buf_data_q, buf_data_d;
  logic                  overflow_q, overflow_d;
  logic [2:0]            bank_q, bank_d;
  logic [1:0]            scheme_q, scheme_d;

  logic                  ctrl_wr, mem_req, grant, hold;
  logic                  hot_en, hot_hit;
  logic [2:0]            hot_bank, entry_bank;
  logic [11:0]           offset;
  logic [ADDR_BITS+14:0] cpu_path;
  logic                  unused_bits;

  assign ctrl_wr = spi_wr && (spi_addr[31:24] == 8'hFF);
  assign mem_req = spi_wr && (spi_addr[31:24] == 8'h00);
  assign ctrl_d  = ctrl_wr ? spi_data : ctrl_q;
  // Hold acts on the incoming control byte so RUN->LOAD happens the cycle after the write.
  assign hold    = ctrl_d[0];
  assign grant   = buf_full_q && ((state_q != StRun) || !cpu_en);

  assign unused_bits = ^{spi_addr[23:ADDR_BITS], ctrl_q[7:4], ctrl_q[1]};

  // Hotspot decode; offsets relative to the first hotspot only need the low 3 bits.
  assign offset = cpu_addr[11:0];
  assign hot_en = (state_q == StRun) && cpu_en && cpu_addr[12];

  always_comb begin
    hot_hit  = 1'b0;
    hot_bank = bank_q;
    unique case (scheme_q)
      2'b01: begin
        hot_hit  = (offset >= 12'hFF8) && (offset <= 12'hFF9);
        hot_bank = offset[2:0];
      end
      2'b10: begin
        hot_hit  = (offset >= 12'hFF6) && (offset <= 12'hFF9);
        hot_bank = offset[2:0] - 3'd6;
      end
      2'b11: begin
        hot_hit  = (offset >= 12'hFF4) && (offset <= 12'hFFB);
        hot_bank = offset[2:0] - 3'd4;
      end
      default: begin
        hot_hit  = 1'b0;
        hot_bank = bank_q;
      end
    endcase
  end

  always_comb begin
    unique case (ctrl_d[3:2])
      2'b01:   entry_bank = 3'd1;
      2'b10:   entry_bank = 3'd3;
      2'b11:   entry_bank = 3'd7;
      default: entry_bank = 3'd0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bank_d   = bank_q;
    scheme_d = scheme_q;
    unique case (state_q)
      StLoad: begin
        if (!hold) begin
          state_d = StRelease;
          cnt_d   = CntMax;
        end
      end
      StRelease: begin
        if (hold) begin
          state_d = StLoad;
        end else if (cnt_q == '0) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StRun: begin
        if (hold) state_d = StLoad;
        if (hot_en && hot_hit) bank_d = hot_bank;
      end
      default: begin
        state_d = StRelease;
        cnt_d   = CntMax;
      end
    endcase
    if ((state_d == StRelease) && (state_q != StRelease)) begin
      scheme_d = ctrl_d[3:2];
      bank_d   = entry_bank;
    end
  end

  // One-entry pending buffer; a drop sets overflow even alongside a control write.
  always_comb begin
    buf_full_d = buf_full_q;
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    overflow_d = overflow_q;
    if (ctrl_wr) overflow_d = 1'b0;
    if (grant) buf_full_d = 1'b0;
    if (mem_req) begin
      if (!buf_full_q || grant) begin
        buf_full_d = 1'b1;
        buf_addr_d = spi_addr[ADDR_BITS-1:0];
        buf_data_d = spi_data;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StRelease;
      cnt_q      <= CntMax;
      ctrl_q     <= 8'h00;
      buf_full_q <= 1'b0;
      buf_addr_q <= '0;
      buf_data_q <= 8'h00;
      overflow_q <= 1'b0;
      bank_q     <= 3'd0;
      scheme_q   <= 2'b00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ctrl_q     <= ctrl_d;
      buf_full_q <= buf_full_d;
      buf_addr_q <= buf_addr_d;
      buf_data_q <= buf_data_d;
      overflow_q <= overflow_d;
      bank_q     <= bank_d;
      scheme_q   <= scheme_d;
    end
  end

  always_comb begin
    cpu_path  = {{ADDR_BITS{1'b0}}, bank_q, cpu_addr[11:0]};
    mem_we    = grant;
    mem_addr  = grant ? buf_addr_q : cpu_path[ADDR_BITS-1:0];
    mem_wdata = buf_data_q;
    cpu_reset = (state_q != StRun);
    spi_busy  = buf_full_q;
    overflow  = overflow_q;
    bank      = bank_q;
    scheme    = scheme_q;
  end

endmodule

// File: tb/tb_cart_bus_arbiter.sv
// Directed self-checking bench for cart_bus_arbiter: reset sequencing, loads,
// bank hotspots, CPU/SPI contention, overflow and reset during a load.
module tb_cart_bus_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cpu_en;
  logic [12:0] cpu_addr;
  logic        spi_wr;
  logic [31:0] spi_addr;
  logic [7:0]  spi_data;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic        cpu_reset;
  logic        spi_busy;
  logic        overflow;
  logic [2:0]  bank;
  logic [1:0]  scheme;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  cart_bus_arbiter #(
    .ADDR_BITS      (15),
    .RELEASE_CYCLES (16)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .cpu_en    (cpu_en),
    .cpu_addr  (cpu_addr),
    .spi_wr    (spi_wr),
    .spi_addr  (spi_addr),
    .spi_data  (spi_data),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .cpu_reset (cpu_reset),
    .spi_busy  (spi_busy),
    .overflow  (overflow),
    .bank      (bank),
    .scheme    (scheme)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic spi_write(input logic [31:0] a, input logic [7:0] d);
    spi_wr   = 1'b1;
    spi_addr = a;
    spi_data = d;
    tick();
    spi_wr = 1'b0;
  endtask

  // Counts cycles with cpu_reset high starting from the current cycle (bounded).
  task automatic count_reset(output int n, output bit we_seen);
    n       = 0;
    we_seen = 1'b0;
    @(negedge clk_i);
    while (cpu_reset && n < 40) begin
      if (mem_we) we_seen = 1'b1;
      n++;
      @(negedge clk_i);
    end
    tick();
  endtask

  logic [12:0] hs_addr [5] = '{13'h0FF8, 13'h1FF9, 13'h1FFA, 13'h1FF6, 13'h1FF5};
  logic [2:0]  hs_bank [5] = '{3'd1, 3'd3, 3'd3, 3'd0, 3'd0};

  initial begin
    int n;
    bit we_seen;
    int pulses;

    rst_i    = 1'b1;
    cpu_en   = 1'b0;
    cpu_addr = 13'h0100;
    spi_wr   = 1'b0;
    spi_addr = 32'h0;
    spi_data = 8'h0;
    tick();
    tick();
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_mem_we", mem_we, 0);
    check("rst_busy", spi_busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_bank", bank, 0);
    check("rst_scheme", scheme, 0);

    // Preloaded image released after reset
    rst_i = 1'b0;
    count_reset(n, we_seen);
    check("boot_release_len", n, 16);
    check("boot_no_we", we_seen, 0);

    // Load one byte under hold, then release into F8
    spi_write(32'hFF00_0000, 8'h05);
    check("hold_reset", cpu_reset, 1);
    spi_write(32'h0000_1234, 8'hAB);
    check("ld_we", mem_we, 1);
    check("ld_addr", mem_addr, 15'h1234);
    check("ld_data", mem_wdata, 8'hAB);
    check("ld_busy", spi_busy, 1);
    tick();
    check("ld_we_once", mem_we, 0);
    spi_write(32'hFF00_0000, 8'h04);
    check("f8_bank", bank, 1);
    check("f8_scheme", scheme, 2'b01);
    count_reset(n, we_seen);
    check("f8_release_len", n, 16);

    // F6 scheme and hotspot table
    spi_write(32'hFF00_0000, 8'h09);
    spi_write(32'hFF00_0000, 8'h08);
    check("f6_bank", bank, 3);
    check("f6_scheme", scheme, 2'b10);
    count_reset(n, we_seen);
    check("f6_release_len", n, 16);
    cpu_en   = 1'b1;
    cpu_addr = 13'h1FF7;
    @(negedge clk_i);
    check("hs_old_bank_addr", mem_addr, 15'h3FF7);
    tick();
    cpu_en   = 1'b0;
    cpu_addr = 13'h1123;
    @(negedge clk_i);
    check("hs_bank_1ff7", bank, 1);
    check("hs_mem_addr", mem_addr, 15'h1123);
    for (int i = 0; i < 5; i++) begin
      tick();
      cpu_en   = 1'b1;
      cpu_addr = hs_addr[i];
      tick();
      cpu_en = 1'b0;
      check($sformatf("hs_bank_%0h", hs_addr[i]), bank, hs_bank[i]);
    end

    // CPU holds the port 3 cycles while a write is pending; second write drops
    cpu_addr = 13'h0100;
    cpu_en   = 1'b1;
    spi_wr   = 1'b1;
    spi_addr = 32'h0000_0042;
    spi_data = 8'h5A;
    @(negedge clk_i);
    check("ct_we_a", mem_we, 0);
    tick();
    spi_addr = 32'h0000_0043;
    spi_data = 8'h77;
    @(negedge clk_i);
    check("ct_we_b", mem_we, 0);
    check("ct_busy_b", spi_busy, 1);
    tick();
    spi_wr = 1'b0;
    @(negedge clk_i);
    check("ct_we_c", mem_we, 0);
    check("ct_overflow", overflow, 1);
    tick();
    cpu_en = 1'b0;
    @(negedge clk_i);
    check("ct_we_d", mem_we, 1);
    check("ct_addr_d", mem_addr, 15'h0042);
    check("ct_data_d", mem_wdata, 8'h5A);
    tick();
    @(negedge clk_i);
    check("ct_busy_e", spi_busy, 0);
    check("ct_we_e", mem_we, 0);
    tick();

    // Back-to-back writes in LOAD
    spi_write(32'hFF00_0000, 8'h01);
    check("ld8_ovf_clear", overflow, 0);
    check("ld8_reset", cpu_reset, 1);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      spi_wr   = (i < 8);
      spi_addr = 32'h0000_0200 + 32'(i);
      spi_data = 8'h10 + 8'(i);
      @(negedge clk_i);
      if (mem_we) begin
        pulses++;
        check($sformatf("ld8_data_%0d", i), mem_wdata, 8'h10 + 8'(i - 1));
      end
      tick();
    end
    spi_wr = 1'b0;
    check("ld8_pulses", pulses, 8);
    check("ld8_overflow", overflow, 0);

    // Reset while a byte is pending in LOAD
    spi_write(32'h0000_0055, 8'h99);
    check("rl_busy", spi_busy, 1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("rl_cpu_reset", cpu_reset, 1);
    check("rl_mem_we", mem_we, 0);
    check("rl_busy0", spi_busy, 0);
    check("rl_overflow", overflow, 0);
    check("rl_bank", bank, 0);
    check("rl_scheme", scheme, 0);
    @(negedge clk_i);
    check("rl_no_we", mem_we, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
